// File: rtl/debug_ocimem_pkg.sv
// debug_ocimem_pkg: shared constants and types for the debug monitor RAM controller
// Contents: jdo field positions, FSM state enum, control-register bit indices, RAM width.
// Optional feature macro: DEBUG_OCIMEM_PARITY_EN (adds an even-parity bit to every RAM word).
package debug_ocimem_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_RD       = 35;
    localparam int JDO_CLR      = 34;
    localparam int JDO_GO       = 33;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_WD_LSB   = 3;

    localparam int CTRL_READY = 0;
    localparam int CTRL_ERROR = 1;
    localparam int CTRL_GO    = 2;

`ifdef DEBUG_OCIMEM_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif

    typedef enum logic [2:0] {
        IDLE,
        JRD,
        JRD_CAP,
        JWR,
        CRD
    } state_t;

endpackage

// File: rtl/debug_ocimem_ram.sv
// debug_ocimem_ram: single-port synchronous RAM with byte enables and 1-cycle read latency
module debug_ocimem_ram
  import debug_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [RAM_W-1:0]  q
);
  logic [RAM_W-1:0] mem [2**ADDR_W];
  logic [31:0]      merged;
  logic [RAM_W-1:0] wword;
  always_comb begin
    merged = mem[addr][31:0];
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : merged[8*i +: 8];
  end
`ifdef DEBUG_OCIMEM_PARITY_EN
  assign wword = {^merged, merged};
`else
  assign wword = merged;
`endif
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wword;
    q <= mem[addr];
  end
endmodule

// File: rtl/debug_ocimem_ctrl.sv
// debug_ocimem_ctrl: debug monitor RAM owner, arbitrating JTAG commands against the CPU debug slave
// Ports: clk, reset_n (async active-low); jdo[37:0] + take_action_ocimem_a/_b, take_no_action_ocimem_a
//        from the JTAG sysclk stage; av_* CPU slave (av_address MSB selects the control register);
//        MonDReg, monitor_ready, monitor_error, monitor_go back to the debug wrapper.
// Optional feature macro: DEBUG_OCIMEM_PARITY_EN (parity check on RAM reads sets monitor_error).
module debug_ocimem_ctrl
    import debug_ocimem_pkg::*;
#(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W:0]   av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go
);

    state_t            state;
    logic [ADDR_W-1:0] jaddr;
    logic [31:0]       jwdata;
    logic              cpu_ctrl;
    logic              idle, j_a, j_rd, j_wr, jtag_req, jclr, jgo;
    logic              cpu_go, cpu_rd, cpu_wr, ctrl_sel, ctrl_we;
    logic              ram_we, perr, perr_hit;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  q;
    logic              unused;

    assign unused = ^{jdo[JDO_W-1:JDO_RD+1], jdo[JDO_WD_LSB-1:0]};

    // Strobes are only honoured in IDLE; the FSM leaving IDLE is the single pending slot.
    assign idle     = state == IDLE;
    assign j_a      = idle & take_action_ocimem_a;
    assign j_wr     = idle & take_action_ocimem_b;
    assign j_rd     = idle & ~take_action_ocimem_b &
                      (take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RD]));
    assign jtag_req = j_wr | j_rd;
    assign jclr     = j_a & jdo[JDO_CLR];
    assign jgo      = j_a & jdo[JDO_GO];

    assign ctrl_sel = av_address[ADDR_W];
    assign cpu_go   = idle & ~jtag_req;
    assign cpu_rd   = cpu_go & av_read;
    assign cpu_wr   = cpu_go & av_write & ~av_read;
    assign ctrl_we  = cpu_wr & av_debugaccess & ctrl_sel & av_byteenable[0];

    assign av_waitrequest = av_read ? state != CRD : av_write & ~cpu_go;
    assign av_readdata    = state != CRD ? 32'h0 :
                            cpu_ctrl ? {29'b0, monitor_go, monitor_error, monitor_ready} : q[31:0];

    // Gating with reset_n kills a write whose cycle is cut short by reset.
    assign ram_we   = reset_n & ((state == JWR) | (cpu_wr & av_debugaccess & ~ctrl_sel));
    assign ram_addr = (state == JRD || state == JWR) ? jaddr : av_address[ADDR_W-1:0];

`ifdef DEBUG_OCIMEM_PARITY_EN
    assign perr = ^q;
`else
    assign perr = 1'b0;
`endif
    assign perr_hit = perr & ((state == JRD_CAP) | ((state == CRD) & ~cpu_ctrl));

    debug_ocimem_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (state == JWR ? 4'hF : av_byteenable),
        .addr  (ram_addr),
        .wdata (state == JWR ? jwdata : av_writedata),
        .q     (q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            jaddr         <= '0;
            jwdata        <= '0;
            cpu_ctrl      <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
        end else begin
            if (j_a)
                jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (j_wr)
                jwdata <= jdo[JDO_WD_LSB +: 32];
            if (cpu_rd)
                cpu_ctrl <= ctrl_sel;
            // A JTAG clear in the same cycle as a CPU set takes precedence.
            monitor_ready <= jclr ? 1'b0 : (ctrl_we & av_writedata[CTRL_READY]) | monitor_ready;
            monitor_error <= jclr ? 1'b0 : (ctrl_we & av_writedata[CTRL_ERROR]) | perr_hit | monitor_error;
            monitor_go    <= jgo ? 1'b1 : ~(ctrl_we & av_writedata[CTRL_READY]) & monitor_go;
            case (state)
                IDLE:    state <= j_wr ? JWR : j_rd ? JRD : cpu_rd ? CRD : IDLE;
                JRD:     state <= JRD_CAP;
                JRD_CAP: begin
                    MonDReg <= q[31:0];
                    jaddr   <= jaddr + ADDR_W'(1);
                    state   <= IDLE;
                end
                JWR: begin
                    jaddr <= jaddr + ADDR_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// tb_debug_ocimem_ctrl: directed self-checking bench for debug_ocimem_ctrl
module tb_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [8:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic        av_debugaccess = 1'b0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    int passed = 0;
    int total  = 0;

    debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_debugaccess          (av_debugaccess),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [37:0] jcmd(input logic rd, input logic clr, input logic go, input logic [7:0] a);
        return (38'(a) << 17) | (38'(rd) << 35) | (38'(clr) << 34) | (38'(go) << 33);
    endfunction

    function automatic logic [37:0] jdat(input logic [31:0] d);
        return 38'(d) << 3;
    endfunction

    // One-cycle strobe, then two more cycles so any JTAG operation has finished.
    task automatic jtag_op(input logic a, input logic b, input logic n, input logic [37:0] d);
        @(negedge clk);
        jdo = d;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = n;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [8:0] a, output logic [31:0] d, output int stall);
        @(negedge clk);
        av_address = a;
        av_read = 1'b1;
        stall = 0;
        #1;
        while (av_waitrequest && stall < 20) begin
            stall++;
            @(negedge clk);
            #1;
        end
        if (stall >= 20) begin
            total++;
            $display("FAIL cpu_read_timeout addr=%h", a);
        end
        d = av_readdata;
        @(negedge clk);
        av_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        int stall;
        @(negedge clk);
        av_address = a;
        av_writedata = d;
        av_byteenable = be;
        av_debugaccess = dbg;
        av_write = 1'b1;
        stall = 0;
        #1;
        while (av_waitrequest && stall < 20) begin
            stall++;
            @(negedge clk);
            #1;
        end
        if (stall >= 20) begin
            total++;
            $display("FAIL cpu_write_timeout addr=%h", a);
        end
        @(negedge clk);
        av_write = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (MonDReg !== 32'h0) $display("FAIL reset_mondreg got=%h exp=0", MonDReg); else passed++;
        total++; if ({monitor_go, monitor_error, monitor_ready} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {monitor_go, monitor_error, monitor_ready}); else passed++;
        total++; if (av_readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", av_readdata); else passed++;
        total++; if (av_waitrequest !== 1'b0) $display("FAIL reset_waitreq got=%b exp=0", av_waitrequest); else passed++;
        total++; if (dut.jaddr !== 8'h00) $display("FAIL reset_jaddr got=%h exp=00", dut.jaddr); else passed++;
    endtask

    task automatic test_jtag_rw();
        jtag_op(1, 0, 0, jcmd(0, 0, 0, 8'h10));
        jtag_op(0, 1, 0, jdat(32'hDEADBEEF));
        total++; if (dut.jaddr !== 8'h11) $display("FAIL jwr_jaddr got=%h exp=11", dut.jaddr); else passed++;
        @(negedge clk);
        jdo = jcmd(1, 0, 0, 8'h10);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        total++; if (MonDReg !== 32'h0) $display("FAIL jrd_early got=%h exp=0", MonDReg); else passed++;
        @(negedge clk);
        total++; if (MonDReg !== 32'hDEADBEEF) $display("FAIL jrd_data got=%h exp=deadbeef", MonDReg); else passed++;
        total++; if (dut.jaddr !== 8'h11) $display("FAIL jrd_jaddr got=%h exp=11", dut.jaddr); else passed++;
        total++; if (monitor_error !== 1'b0) $display("FAIL jrd_noerr got=%b exp=0", monitor_error); else passed++;
    endtask

    task automatic test_stream_wrap();
        jtag_op(1, 0, 0, jcmd(0, 0, 0, 8'hFF));
        jtag_op(0, 1, 0, jdat(32'hCAFE0001));
        total++; if (dut.jaddr !== 8'h00) $display("FAIL wrap_jaddr got=%h exp=00", dut.jaddr); else passed++;
        jtag_op(0, 1, 0, jdat(32'hCAFE0002));
        jtag_op(1, 0, 0, jcmd(0, 0, 0, 8'hFF));
        jtag_op(0, 0, 1, '0);
        total++; if (MonDReg !== 32'hCAFE0001) $display("FAIL stream_ff got=%h exp=cafe0001", MonDReg); else passed++;
        jtag_op(0, 0, 1, '0);
        total++; if (MonDReg !== 32'hCAFE0002) $display("FAIL stream_00 got=%h exp=cafe0002", MonDReg); else passed++;
        total++; if (dut.jaddr !== 8'h01) $display("FAIL stream_jaddr got=%h exp=01", dut.jaddr); else passed++;
    endtask

    task automatic test_arbitration();
        int stall;
        jtag_op(1, 0, 0, jcmd(0, 0, 0, 8'hFF));
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        av_address = 9'h010;
        av_read = 1'b1;
        stall = 0;
        #1;
        if (av_waitrequest) stall++;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        #1;
        while (av_waitrequest && stall < 20) begin
            stall++;
            @(negedge clk);
            #1;
        end
        total++; if (stall !== 4) $display("FAIL arb_stall got=%0d exp=4", stall); else passed++;
        total++; if (av_readdata !== 32'hDEADBEEF) $display("FAIL arb_cpu_data got=%h exp=deadbeef", av_readdata); else passed++;
        total++; if (MonDReg !== 32'hCAFE0001) $display("FAIL arb_jtag_first got=%h exp=cafe0001", MonDReg); else passed++;
        @(negedge clk);
        av_read = 1'b0;
    endtask

    task automatic test_drop();
        logic [31:0] d;
        int stall;
        cpu_write(9'h030, 32'h55AA55AA, 4'hF, 1'b1);
        cpu_write(9'h031, 32'h00000000, 4'hF, 1'b1);
        jtag_op(1, 0, 0, jcmd(0, 0, 0, 8'h30));
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b1;
        jdo = jdat(32'h12345678);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (MonDReg !== 32'h55AA55AA) $display("FAIL drop_read got=%h exp=55aa55aa", MonDReg); else passed++;
        total++; if (dut.jaddr !== 8'h31) $display("FAIL drop_jaddr got=%h exp=31", dut.jaddr); else passed++;
        cpu_read(9'h031, d, stall);
        total++; if (d !== 32'h0) $display("FAIL drop_ram got=%h exp=0", d); else passed++;
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        int stall;
        jtag_op(1, 0, 0, jcmd(0, 0, 1, 8'h00));
        total++; if (monitor_go !== 1'b1) $display("FAIL hs_go got=%b exp=1", monitor_go); else passed++;
        cpu_write(9'h100, 32'h1, 4'hF, 1'b1);
        total++; if ({monitor_go, monitor_ready} !== 2'b01)
            $display("FAIL hs_ready got=%b exp=01", {monitor_go, monitor_ready}); else passed++;
        cpu_write(9'h100, 32'h2, 4'hF, 1'b1);
        total++; if (monitor_error !== 1'b1) $display("FAIL hs_error got=%b exp=1", monitor_error); else passed++;
        cpu_read(9'h100, d, stall);
        total++; if (d !== 32'h3) $display("FAIL hs_ctrl_read got=%h exp=3", d); else passed++;
        total++; if (stall !== 1) $display("FAIL hs_ctrl_stall got=%0d exp=1", stall); else passed++;
        jtag_op(1, 0, 0, jcmd(0, 1, 0, 8'h00));
        total++; if ({monitor_error, monitor_ready} !== 2'b00)
            $display("FAIL hs_clear got=%b exp=00", {monitor_error, monitor_ready}); else passed++;
        cpu_write(9'h100, 32'h3, 4'hF, 1'b1);
        @(negedge clk);
        jdo = jcmd(0, 1, 0, 8'h00);
        take_action_ocimem_a = 1'b1;
        av_address = 9'h100;
        av_writedata = 32'h3;
        av_byteenable = 4'hF;
        av_debugaccess = 1'b1;
        av_write = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        av_write = 1'b0;
        total++; if ({monitor_error, monitor_ready} !== 2'b00)
            $display("FAIL hs_clear_wins got=%b exp=00", {monitor_error, monitor_ready}); else passed++;
        cpu_write(9'h100, 32'h3, 4'hF, 1'b0);
        total++; if ({monitor_error, monitor_ready} !== 2'b00)
            $display("FAIL hs_nodebug got=%b exp=00", {monitor_error, monitor_ready}); else passed++;
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        int stall;
        cpu_write(9'h020, 32'h11223344, 4'hF, 1'b1);
        cpu_write(9'h020, 32'hAABBCCDD, 4'b0011, 1'b1);
        cpu_read(9'h020, d, stall);
        total++; if (d !== 32'h1122CCDD) $display("FAIL be_lower got=%h exp=1122ccdd", d); else passed++;
        total++; if (stall !== 1) $display("FAIL be_read_stall got=%0d exp=1", stall); else passed++;
        cpu_write(9'h020, 32'hAABBCCDD, 4'b0011, 1'b0);
        cpu_read(9'h020, d, stall);
        total++; if (d !== 32'h1122CCDD) $display("FAIL be_nodebug got=%h exp=1122ccdd", d); else passed++;
    endtask

`ifdef DEBUG_OCIMEM_PARITY_EN
    task automatic test_parity();
        jtag_op(1, 0, 0, jcmd(0, 1, 0, 8'h50));
        jtag_op(0, 1, 0, jdat(32'h12345678));
        dut.u_ram.mem[8'h50][32] = ~dut.u_ram.mem[8'h50][32];
        jtag_op(1, 0, 0, jcmd(1, 0, 0, 8'h50));
        total++; if (monitor_error !== 1'b1) $display("FAIL parity_error got=%b exp=1", monitor_error); else passed++;
        total++; if (MonDReg !== 32'h12345678) $display("FAIL parity_data got=%h exp=12345678", MonDReg); else passed++;
    endtask
`endif

    task automatic test_reset_midop();
        logic [31:0] d;
        int stall;
        cpu_write(9'h040, 32'h0BADF00D, 4'hF, 1'b1);
        jtag_op(1, 0, 0, jcmd(0, 0, 1, 8'h40));
        @(negedge clk);
        jdo = jdat(32'hFFFFFFFF);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (dut.jaddr !== 8'h00) $display("FAIL rst_jaddr got=%h exp=00", dut.jaddr); else passed++;
        total++; if ({monitor_go, MonDReg} !== 33'h0) $display("FAIL rst_outputs got=%h exp=0", {monitor_go, MonDReg}); else passed++;
        cpu_read(9'h040, d, stall);
        total++; if (d !== 32'h0BADF00D) $display("FAIL rst_write_killed got=%h exp=0badf00d", d); else passed++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_jtag_rw();
        test_stream_wrap();
        test_arbitration();
        test_drop();
        test_handshake();
        test_byte_enable();
`ifdef DEBUG_OCIMEM_PARITY_EN
        test_parity();
`endif
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
